// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants and request engine state encoding for the ARP transmit path.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP     = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY   = 16'h0002;
    localparam logic [47:0] ETH_BCAST_MAC    = 48'hFFFF_FFFF_FFFF;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_SEND = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;
    localparam logic [1:0] R_WAIT = 2'd3;

endpackage

// File: rtl/arp_req_retry.sv
// ARP request engine: latches the IP to resolve, schedules transmissions and retries,
// and reports timeout once every attempt has gone unanswered.
module arp_req_retry
    import arp_pkg::*;
#(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_req_valid,
    output logic        s_req_ready,
    input  logic [31:0] s_req_ip,
    input  logic        req_cancel,
    output logic        req_busy,
    output logic        req_timeout,
    output logic        send_due,
    output logic        send_due_next,
    input  logic        sent,
    input  logic        accepted,
    output logic [31:0] req_ip
);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] ip_q, ip_d;
    logic        ready_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        ip_d        = ip_q;
        req_timeout = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (s_req_valid && ready_q) begin
                    ip_d    = s_req_ip;
                    cnt_d   = 8'(RETRY_COUNT);
                    state_d = R_SEND;
                end
            end
            R_SEND: begin
                if (sent) begin
                    cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
                    state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (accepted) begin
                    timer_d = 32'(RETRY_INTERVAL - 1);
                    state_d = R_WAIT;
                end
            end
            default: begin
                if (timer_q != 32'd0) begin
                    timer_d = timer_q - 32'd1;
                end else if (cnt_q != 8'd0) begin
                    state_d = R_SEND;
                end else begin
                    req_timeout = !req_cancel;
                    state_d     = R_IDLE;
                end
            end
        endcase
        // Cancel wins over any progress; a frame already in the slot is left to drain.
        if (req_cancel && state_q != R_IDLE) begin
            state_d = R_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= R_IDLE;
            cnt_q   <= 8'd0;
            timer_q <= 32'd0;
            ip_q    <= 32'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ip_q    <= ip_d;
            ready_q <= (state_d == R_IDLE);
        end
    end

    assign s_req_ready   = ready_q;
    assign req_busy      = (state_q != R_IDLE);
    assign send_due      = (state_q == R_SEND);
    assign send_due_next = (state_d == R_SEND);
    assign req_ip        = ip_q;

endmodule

// File: rtl/arp_tx_sched.sv
// Shares the single ARP frame slot feeding arp_eth_tx between the reply path and the
// retrying request engine, alternating when both compete so neither starves.
module arp_tx_sched
    import arp_pkg::*;
#(
    parameter int unsigned RETRY_COUNT    = 4,
    parameter int unsigned RETRY_INTERVAL = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        s_reply_valid,
    output logic        s_reply_ready,
    input  logic [47:0] s_reply_mac,
    input  logic [31:0] s_reply_ip,
    input  logic        s_req_valid,
    output logic        s_req_ready,
    input  logic [31:0] s_req_ip,
    input  logic        req_cancel,
    output logic        req_busy,
    output logic        req_timeout,
    output logic        m_frame_valid,
    input  logic        m_frame_ready,
    output logic [47:0] m_eth_dest_mac,
    output logic [47:0] m_eth_src_mac,
    output logic [15:0] m_eth_type,
    output logic [15:0] m_arp_htype,
    output logic [15:0] m_arp_ptype,
    output logic [15:0] m_arp_oper,
    output logic [47:0] m_arp_sha,
    output logic [31:0] m_arp_spa,
    output logic [47:0] m_arp_tha,
    output logic [31:0] m_arp_tpa
);

    logic        send_due, send_due_next, sent, accepted;
    logic [31:0] req_ip;
    logic        slot_free, reply_hs, m_valid_d;
    logic        is_req_q, last_reply_q, last_reply_d, reply_ready_q;

    arp_req_retry #(
        .RETRY_COUNT   (RETRY_COUNT),
        .RETRY_INTERVAL(RETRY_INTERVAL)
    ) u_retry (
        .clk          (clk),
        .rst          (rst),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_ip     (s_req_ip),
        .req_cancel   (req_cancel),
        .req_busy     (req_busy),
        .req_timeout  (req_timeout),
        .send_due     (send_due),
        .send_due_next(send_due_next),
        .sent         (sent),
        .accepted     (accepted),
        .req_ip       (req_ip)
    );

    // reply_ready_q is only ever set for a cycle in which the slot is known to be empty.
    assign slot_free    = !m_frame_valid || m_frame_ready;
    assign reply_hs     = s_reply_valid && reply_ready_q;
    assign sent         = send_due && slot_free && !reply_hs;
    assign accepted     = m_frame_valid && m_frame_ready && is_req_q;
    assign m_valid_d    = reply_hs || sent || (m_frame_valid && !m_frame_ready);
    assign last_reply_d = reply_hs ? 1'b1 : (sent ? 1'b0 : last_reply_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_frame_valid  <= 1'b0;
            is_req_q       <= 1'b0;
            last_reply_q   <= 1'b0;
            reply_ready_q  <= 1'b0;
            m_eth_dest_mac <= 48'd0;
            m_eth_src_mac  <= 48'd0;
            m_eth_type     <= 16'd0;
            m_arp_htype    <= 16'd0;
            m_arp_ptype    <= 16'd0;
            m_arp_oper     <= 16'd0;
            m_arp_sha      <= 48'd0;
            m_arp_spa      <= 32'd0;
            m_arp_tha      <= 48'd0;
            m_arp_tpa      <= 32'd0;
        end else begin
            m_frame_valid <= m_valid_d;
            last_reply_q  <= last_reply_d;
            // A due request blocks replies only when a reply took the previous load.
            reply_ready_q <= !m_valid_d && !(send_due_next && last_reply_d);
            if (reply_hs || sent) begin
                is_req_q       <= sent;
                m_eth_dest_mac <= reply_hs ? s_reply_mac : ETH_BCAST_MAC;
                m_eth_src_mac  <= local_mac;
                m_eth_type     <= ETH_TYPE_ARP;
                m_arp_htype    <= ARP_HTYPE_ETH;
                m_arp_ptype    <= ARP_PTYPE_IPV4;
                m_arp_oper     <= reply_hs ? ARP_OPER_REPLY : ARP_OPER_REQUEST;
                m_arp_sha      <= local_mac;
                m_arp_spa      <= local_ip;
                m_arp_tha      <= reply_hs ? s_reply_mac : 48'd0;
                m_arp_tpa      <= reply_hs ? s_reply_ip : req_ip;
            end
        end
    end

    assign s_reply_ready = reply_ready_q;

endmodule
